// File: rtl/portb_mem_arbiter_pkg.sv
// rtl/portb_mem_arbiter_pkg.sv - shared state encoding, default widths and helpers for the port B arbiter
package portb_mem_arbiter_pkg;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/portb_mem_arbiter_if.sv
// rtl/portb_mem_arbiter_if.sv - requester and RAM port B bundle; master = requesters plus RAM, slave = arbiter
interface portb_mem_arbiter_if
    import portb_mem_arbiter_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;

    logic [ADDR_W-1:0]      ram_addr_b;
    logic                   ram_we_b;
    logic [DATA_W-1:0]      ram_data_b;
    logic [DATA_W-1:0]      ram_q_b;

    modport master (
        output req, req_we, req_addr, req_wdata, ram_q_b,
        input  gnt, rvalid, rdata, ram_addr_b, ram_we_b, ram_data_b
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata, ram_q_b,
        output gnt, rvalid, rdata, ram_addr_b, ram_we_b, ram_data_b
    );

endinterface

// File: rtl/portb_mem_arbiter_rr_pick.sv
// rtl/portb_mem_arbiter_rr_pick.sv - combinational round-robin picker: first set req bit upward from ptr with wrap
module portb_mem_arbiter_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    int j;

    always_comb begin
        onehot  = '0;
        idx     = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            // Rotate the search origin to ptr; explicit wrap keeps non-power-of-two NREQ correct.
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any_req && req[j]) begin
                any_req   = 1'b1;
                idx       = IDX_W'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/portb_mem_arbiter.sv
// rtl/portb_mem_arbiter.sv - port B RAM arbiter, single outstanding access; PORTB_ARB_FIXED_PRI_EN selects fixed priority
module portb_mem_arbiter
    import portb_mem_arbiter_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    portb_mem_arbiter_if.slave bus,
    output logic               busy
);

    localparam int IDX_W = idx_width(NREQ);

    arb_state_t state;
    arb_state_t state_nxt;

    logic [NREQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_ptr;

    // Holding registers: the access is frozen at the IDLE->ISSUE edge.
    logic              hold_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic [NREQ-1:0]   hold_gnt;

    logic [NREQ-1:0]   gnt_c;
    logic [NREQ-1:0]   rvalid_c;
    logic [DATA_W-1:0] rdata_c;
    logic              ram_we_c;

`ifdef PORTB_ARB_FIXED_PRI_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] hold_idx;

    assign pick_ptr = rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            hold_idx <= '0;
        end else begin
            if (state == ARB_IDLE && pick_any) begin
                hold_idx <= pick_idx;
            end
            if (state == ARB_ISSUE) begin
                rr_ptr <= (hold_idx == IDX_W'(NREQ - 1)) ? '0 : hold_idx + 1'b1;
            end
        end
    end
`endif

    portb_mem_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .ptr     (pick_ptr),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_gnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && pick_any) begin
                hold_we    <= bus.req_we[pick_idx];
                hold_addr  <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                hold_wdata <= bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                hold_gnt   <= pick_onehot;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_c     = '0;
        rvalid_c  = '0;
        rdata_c   = '0;
        ram_we_c  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                gnt_c     = hold_gnt;
                ram_we_c  = hold_we;
                state_nxt = hold_we ? ARB_IDLE : ARB_RESP;
            end
            ARB_RESP: begin
                // A reset landing in this cycle discards the response outright.
                if (!rst) begin
                    rvalid_c = hold_gnt;
                    rdata_c  = bus.ram_q_b;
                end
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Address and data come straight from the holding registers, so they keep
    // their last value outside ISSUE; only the write strobe is qualified.
    assign bus.ram_addr_b = hold_addr;
    assign bus.ram_data_b = hold_wdata;
    assign bus.ram_we_b   = ram_we_c;
    assign bus.gnt        = gnt_c;
    assign bus.rvalid     = rvalid_c;
    assign bus.rdata      = rdata_c;
    assign busy           = (state != ARB_IDLE);

endmodule

// File: tb/tb_portb_mem_arbiter.sv
// tb/tb_portb_mem_arbiter.sv - directed self-checking bench for portb_mem_arbiter with a behavioural port B RAM
module tb_portb_mem_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic ram_init;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    portb_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    portb_mem_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    logic [DATA_W-1:0] mem [0:1023];

    // Registered-read RAM, one cycle latency; preload pattern A000+addr with 0x05A = BEEF.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= (i == 32'h05A) ? 16'hBEEF : 16'hA000 + 16'(i);
            end
        end else if (bus.ram_we_b) begin
            mem[bus.ram_addr_b] <= bus.ram_data_b;
        end
        bus.ram_q_b <= mem[bus.ram_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        bus.req[i]                         = 1'b1;
        bus.req_we[i]                      = we;
        bus.req_addr[i*ADDR_W +: ADDR_W]   = a;
        bus.req_wdata[i*DATA_W +: DATA_W]  = d;
    endtask

    initial begin
        int exp_i;
        rst           = 1'b1;
        ram_init      = 1'b1;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b0, 10'h010 + 10'(i), 16'h0000);
        end

        // Reset held three cycles with all requesters active.
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt", bus.gnt, 32'h0);
            check("rst_rvalid", bus.rvalid, 32'h0);
            check("rst_rdata", bus.rdata, 32'h0);
            check("rst_we", bus.ram_we_b, 32'h0);
            check("rst_addr", bus.ram_addr_b, 32'h0);
            check("rst_data", bus.ram_data_b, 32'h0);
            check("rst_busy", busy, 32'h0);
        end
        rst      = 1'b0;
        ram_init = 1'b0;

        // Eight back-to-back reads with all four requesting.
        for (int k = 0; k < 8; k++) begin
`ifdef PORTB_ARB_FIXED_PRI_EN
            exp_i = 0;
`else
            exp_i = k % 4;
`endif
            @(negedge clk);
            check("rr_gnt", bus.gnt, 32'(1) << exp_i);
            check("rr_busy_issue", busy, 32'h1);
            check("rr_addr", bus.ram_addr_b, 32'h010 + 32'(exp_i));
            check("rr_we", bus.ram_we_b, 32'h0);
            @(negedge clk);
            check("rr_rvalid", bus.rvalid, 32'(1) << exp_i);
            check("rr_rdata", bus.rdata, 32'hA010 + 32'(exp_i));
            check("rr_gnt_resp", bus.gnt, 32'h0);
            @(negedge clk);
            check("rr_busy_idle", busy, 32'h0);
            check("rr_rvalid_idle", bus.rvalid, 32'h0);
        end
        bus.req = '0;

        // Single read of preloaded BEEF by requester 2.
        set_req(2, 1'b0, 10'h05A, 16'h0000);
        @(negedge clk);
        check("rd_gnt", bus.gnt, 32'h4);
        check("rd_addr", bus.ram_addr_b, 32'h05A);
        check("rd_busy1", busy, 32'h1);
        bus.req[2] = 1'b0;
        @(negedge clk);
        check("rd_rvalid", bus.rvalid, 32'h4);
        check("rd_rdata", bus.rdata, 32'hBEEF);
        check("rd_busy2", busy, 32'h1);
        @(negedge clk);
        check("rd_busy_end", busy, 32'h0);
        check("rd_rvalid_end", bus.rvalid, 32'h0);
        check("rd_rdata_end", bus.rdata, 32'h0);

        // Requester 1 writes 1234 to 3FF, then requester 3 reads it back.
        set_req(1, 1'b1, 10'h3FF, 16'h1234);
        @(negedge clk);
        check("wr_gnt", bus.gnt, 32'h2);
        check("wr_we", bus.ram_we_b, 32'h1);
        check("wr_addr", bus.ram_addr_b, 32'h3FF);
        check("wr_data", bus.ram_data_b, 32'h1234);
        bus.req[1] = 1'b0;
        @(negedge clk);
        check("wr_we_after", bus.ram_we_b, 32'h0);
        check("wr_gnt_after", bus.gnt, 32'h0);
        check("wr_busy_after", busy, 32'h0);
        check("wr_addr_hold", bus.ram_addr_b, 32'h3FF);
        set_req(3, 1'b0, 10'h3FF, 16'h0000);
        @(negedge clk);
        check("rb_gnt", bus.gnt, 32'h8);
        check("rb_we", bus.ram_we_b, 32'h0);
        bus.req[3] = 1'b0;
        @(negedge clk);
        check("rb_rvalid", bus.rvalid, 32'h8);
        check("rb_rdata", bus.rdata, 32'h1234);
        @(negedge clk);
        check("rb_busy_end", busy, 32'h0);

        // Reset during RESP: response dropped, pointer back to requester 0.
        set_req(2, 1'b0, 10'h05A, 16'h0000);
        @(negedge clk);
        check("mr_gnt", bus.gnt, 32'h4);
        bus.req[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b0, 10'h05A, 16'h0000);
        end
        #1;
        check("mr_rvalid_resp", bus.rvalid, 32'h0);
        check("mr_rdata_resp", bus.rdata, 32'h0);
        @(negedge clk);
        check("mr_rvalid_rst", bus.rvalid, 32'h0);
        check("mr_busy_rst", busy, 32'h0);
        check("mr_gnt_rst", bus.gnt, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("mr_gnt_next", bus.gnt, 32'h1);
        check("mr_addr_next", bus.ram_addr_b, 32'h05A);
        bus.req = '0;
        @(negedge clk);
        check("mr_rvalid_next", bus.rvalid, 32'h1);
        check("mr_rdata_next", bus.rdata, 32'hBEEF);
        @(negedge clk);
        check("mr_busy_end", busy, 32'h0);

`ifdef PORTB_ARB_FIXED_PRI_EN
        // Requesters 1 and 3 held: 1 always wins until it drops.
        set_req(1, 1'b0, 10'h011, 16'h0000);
        set_req(3, 1'b0, 10'h013, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fp_gnt1", bus.gnt, 32'h2);
            @(negedge clk);
            check("fp_rvalid1", bus.rvalid, 32'h2);
            check("fp_rdata1", bus.rdata, 32'hA011);
            @(negedge clk);
            check("fp_busy_idle", busy, 32'h0);
        end
        bus.req[1] = 1'b0;
        @(negedge clk);
        check("fp_gnt3", bus.gnt, 32'h8);
        bus.req = '0;
        @(negedge clk);
        check("fp_rvalid3", bus.rvalid, 32'h8);
        check("fp_rdata3", bus.rdata, 32'hA013);
        @(negedge clk);
        check("fp_busy_end", busy, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
